mc_control: RTL and testbench

Multicycle main control unit for the MIPS datapath. It is a Moore-style FSM (with `mem_ready`-qualified strobes) that sequences fetch, decode, execute, memory and writeback. It drives the PC update controls (`PCWrite`, `PCWriteCond`, `PCSource`) and all other datapath enables. It sits between the instruction register opcode field and the PC, memory, register file and ALU-control blocks.

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_control_if.sv | 32 +++
 rtl/mc_out_decode.sv | 70 +++++++
 rtl/mc_control.sv | 73 +++++++
 tb/tb_mc_control.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PCS_INC    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Opcode/handshake inputs and datapath control outputs of mc_control.
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, illegal, state
  );
endinterface

// File: rtl/mc_out_decode.sv
// Moore output decode: state plus mem_ready strobes to datapath controls.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control vector; unlisted fields and unreachable codes stay 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCS_INC;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: state register and next-state logic.
module mc_control
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   illegal;

  // State register; active-low rst forces RESET without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  // Next-state: dispatch on opcode in DECODE, stall on mem_ready in memory states.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Illegal-opcode strobe, only meaningful while decoding.
  always_comb begin
    illegal = (state_q == S_DECODE) && !is_known_op(bus.opcode);
  end

  mc_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.illegal     = illegal;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: table-driven per-cycle vectors through a scoreboard queue.
module tb_mc_control;

  logic clk;
  logic rst;
  mc_control_if bus ();

  mc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] out;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  //  RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,illegal}
  function automatic logic [17:0] pack_out();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.RegDst,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.illegal};
  endfunction

  function automatic logic [17:0] model(input logic [3:0] st, input logic mr, input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, asa;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, asa} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd1:       begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd2:       asb = 2'b11;
      4'd3, 4'd11: begin asa = 1'b1; asb = 2'b10; end
      4'd4:       begin mrd = 1'b1; iord = 1'b1; end
      4'd5:       begin rw = 1'b1; m2r = 1'b1; end
      4'd6:       begin mwr = 1'b1; iord = 1'b1; end
      4'd7:       begin asa = 1'b1; aop = 2'b10; end
      4'd8:       begin rw = 1'b1; rdst = 1'b1; end
      4'd9:       begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd10:      begin pcw = 1'b1; pcs = 2'b10; end
      4'd12:      rw = 1'b1;
      default:    ;
    endcase
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, m2r, rw, rdst, asa, asb, aop, ill};
  endfunction

  task automatic check_now(input string name, input logic [3:0] est, input logic [17:0] eout);
    logic [17:0] act;
    act = pack_out();
    total++;
    if (bus.state !== est) begin
      bad++;
      $display("FAIL %s state: got %0d want %0d", name, bus.state, est);
    end
    total++;
    if (act !== eout) begin
      bad++;
      $display("FAIL %s outputs: got %b want %b", name, act, eout);
    end
    total++;
    if ((bus.PCWrite && bus.PCWriteCond) || (bus.MemRead && bus.MemWrite)) begin
      bad++;
      $display("FAIL %s invariant: got pcw=%b pcwc=%b mr=%b mw=%b want no overlap",
               name, bus.PCWrite, bus.PCWriteCond, bus.MemRead, bus.MemWrite);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check at the falling edge.
  task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] st, input logic ill);
    exp_t e;
    bus.opcode    = op;
    bus.mem_ready = mr;
    sb.push_back('{st: st, out: model(st, mr, ill)});
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue want entry");
    end else begin
      e = sb.pop_front();
      check_now("step", e.st, e.out);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, RT = 6'b000000, ADDI = 6'b001000, BAD = 6'b111111;

  initial begin
    // lw, zero wait
    tbl.push_back('{LW, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd2, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd3, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd4, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd5, 1'b0});
    // beq
    tbl.push_back('{BEQ, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{BEQ, 1'b1, 4'd2, 1'b0});
    tbl.push_back('{BEQ, 1'b1, 4'd9, 1'b0});
    // j
    tbl.push_back('{J, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{J, 1'b1, 4'd2, 1'b0});
    tbl.push_back('{J, 1'b1, 4'd10, 1'b0});
    // sw, three wait cycles in MEM_WR
    tbl.push_back('{SW, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{SW, 1'b1, 4'd2, 1'b0});
    tbl.push_back('{SW, 1'b1, 4'd3, 1'b0});
    tbl.push_back('{SW, 1'b0, 4'd6, 1'b0});
    tbl.push_back('{SW, 1'b0, 4'd6, 1'b0});
    tbl.push_back('{SW, 1'b0, 4'd6, 1'b0});
    tbl.push_back('{SW, 1'b1, 4'd6, 1'b0});
    // R-type with two FETCH wait cycles
    tbl.push_back('{RT, 1'b0, 4'd1, 1'b0});
    tbl.push_back('{RT, 1'b0, 4'd1, 1'b0});
    tbl.push_back('{RT, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{RT, 1'b1, 4'd2, 1'b0});
    tbl.push_back('{RT, 1'b1, 4'd7, 1'b0});
    tbl.push_back('{RT, 1'b1, 4'd8, 1'b0});
    // addi
    tbl.push_back('{ADDI, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{ADDI, 1'b1, 4'd2, 1'b0});
    tbl.push_back('{ADDI, 1'b1, 4'd11, 1'b0});
    tbl.push_back('{ADDI, 1'b1, 4'd12, 1'b0});
    // illegal opcode
    tbl.push_back('{BAD, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{BAD, 1'b1, 4'd2, 1'b1});
    // lw with one MEM_RD wait
    tbl.push_back('{LW, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd2, 1'b0});
    tbl.push_back('{LW, 1'b0, 4'd3, 1'b0});
    tbl.push_back('{LW, 1'b0, 4'd4, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd4, 1'b0});
    tbl.push_back('{LW, 1'b1, 4'd5, 1'b0});
    tbl.push_back('{RT, 1'b0, 4'd1, 1'b0});

    // Reset held low, then released between edges.
    rst = 1'b0;
    bus.opcode = RT;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_hold", 4'd0, 18'd0);
    rst = 1'b1;
    step(RT, 1'b1, 4'd0, 1'b0);

    for (int unsigned i = 0; i < tbl.size(); i++)
      step(tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].ill);

    // Async reset landing in R_EXEC.
    step(RT, 1'b1, 4'd1, 1'b0);
    step(RT, 1'b1, 4'd2, 1'b0);
    bus.opcode = RT;
    bus.mem_ready = 1'b1;
    #1;
    check_now("in_rexec", 4'd7, model(4'd7, 1'b1, 1'b0));
    rst = 1'b0;
    #1;
    check_now("rst_rexec", 4'd0, 18'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(RT, 1'b1, 4'd0, 1'b0);
    step(SW, 1'b1, 4'd1, 1'b0);
    step(SW, 1'b1, 4'd2, 1'b0);
    step(SW, 1'b1, 4'd3, 1'b0);

    // Async reset during a pending MEM_WR wait.
    bus.mem_ready = 1'b0;
    #1;
    check_now("in_memwr", 4'd6, model(4'd6, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    check_now("rst_memwr", 4'd0, 18'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(RT, 1'b0, 4'd0, 1'b0);
    step(RT, 1'b0, 4'd1, 1'b0);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
